// File: rtl/receive_fsm_pkg.sv
// Shared types and constants for the nibble-serial command receiver.
package receive_fsm_pkg;

    localparam int NIBBLE_W = 4;
    localparam int OPC_W    = 8;

    localparam logic [NIBBLE_W-1:0] SYNC_NIBBLE_DEFAULT = 4'hC;

    typedef enum logic [2:0] {
        IDLE,
        GET_OP,
        GET_A,
        GET_B,
        GET_C_LO,
        GET_C_HI
    } state_e;

endpackage

// File: rtl/receive_timeout.sv
// Mid-frame inactivity watchdog: counts stalled cycles inside a frame and
// flags an abort on the cycle the count reaches TIMEOUT_CYCLES.
module receive_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_frame_i,
    input  logic valid_i,
    output logic abort_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign abort_o = in_frame_i && !valid_i
                     && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (valid_i || !in_frame_i || abort_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/receive_fsm_core.sv
// Nibble-serial command receiver: sync, opcode, A, B, C_lo, C_hi -> parallel op.
// Define RECEIVE_FSM_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES.
module receive_fsm_core
    import receive_fsm_pkg::*;
#(
    parameter logic [NIBBLE_W-1:0] SYNC_NIBBLE = SYNC_NIBBLE_DEFAULT
`ifdef RECEIVE_FSM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd_data_valid_i,
    input  logic [NIBBLE_W-1:0] rd_data_i,
    output logic [NIBBLE_W-1:0] op_a,
    output logic [NIBBLE_W-1:0] op_b,
    output logic [OPC_W-1:0]    op_c,
    output logic [NIBBLE_W-1:0] op_op,
    output logic                op_valid_o
);

    state_e              state_q, state_d;
    logic [NIBBLE_W-1:0] stg_op_q, stg_op_d;
    logic [NIBBLE_W-1:0] stg_a_q, stg_a_d;
    logic [NIBBLE_W-1:0] stg_b_q, stg_b_d;
    logic [NIBBLE_W-1:0] stg_clo_q, stg_clo_d;
    logic [NIBBLE_W-1:0] op_op_q, op_op_d;
    logic [NIBBLE_W-1:0] op_a_q, op_a_d;
    logic [NIBBLE_W-1:0] op_b_q, op_b_d;
    logic [OPC_W-1:0]    op_c_q, op_c_d;
    logic                op_valid_q, op_valid_d;

`ifdef RECEIVE_FSM_TIMEOUT_EN
    logic timeout_abort;

    receive_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .in_frame_i (state_q != IDLE),
        .valid_i    (rd_data_valid_i),
        .abort_o    (timeout_abort)
    );
`endif

    always_comb begin
        state_d    = state_q;
        stg_op_d   = stg_op_q;
        stg_a_d    = stg_a_q;
        stg_b_d    = stg_b_q;
        stg_clo_d  = stg_clo_q;
        op_op_d    = op_op_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_c_d     = op_c_q;
        op_valid_d = 1'b0;

        if (rd_data_valid_i) begin
            case (state_q)
                IDLE: begin
                    if (rd_data_i == SYNC_NIBBLE) begin
                        state_d = GET_OP;
                    end
                end
                GET_OP: begin
                    stg_op_d = rd_data_i;
                    state_d  = GET_A;
                end
                GET_A: begin
                    stg_a_d = rd_data_i;
                    state_d = GET_B;
                end
                GET_B: begin
                    stg_b_d = rd_data_i;
                    state_d = GET_C_LO;
                end
                GET_C_LO: begin
                    stg_clo_d = rd_data_i;
                    state_d   = GET_C_HI;
                end
                GET_C_HI: begin
                    // All outputs load together so a partial frame is never visible.
                    op_op_d    = stg_op_q;
                    op_a_d     = stg_a_q;
                    op_b_d     = stg_b_q;
                    op_c_d     = {rd_data_i, stg_clo_q};
                    op_valid_d = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef RECEIVE_FSM_TIMEOUT_EN
        else if (timeout_abort) begin
            state_d   = IDLE;
            stg_op_d  = '0;
            stg_a_d   = '0;
            stg_b_d   = '0;
            stg_clo_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            stg_op_q   <= '0;
            stg_a_q    <= '0;
            stg_b_q    <= '0;
            stg_clo_q  <= '0;
            op_op_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_c_q     <= '0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stg_op_q   <= stg_op_d;
            stg_a_q    <= stg_a_d;
            stg_b_q    <= stg_b_d;
            stg_clo_q  <= stg_clo_d;
            op_op_q    <= op_op_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_c_q     <= op_c_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign op_op      = op_op_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_c       = op_c_q;
    assign op_valid_o = op_valid_q;

endmodule

// File: tb/tb_receive_fsm_core.sv
// Bench for receive_fsm_core: vector table, hand-written corner sequences and
// randomized traffic against a queue-based frame model.
module tb_receive_fsm_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_data_valid_i;
    logic [3:0] rd_data_i;
    logic [3:0] op_a, op_b, op_op;
    logic [7:0] op_c;
    logic       op_valid_o;

    always #5 clk = ~clk;

    receive_fsm_core dut (
        .clk             (clk),
        .reset           (reset),
        .rd_data_valid_i (rd_data_valid_i),
        .rd_data_i       (rd_data_i),
        .op_a            (op_a),
        .op_b            (op_b),
        .op_c            (op_c),
        .op_op           (op_op),
        .op_valid_o      (op_valid_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pulse_cycles[$];

    // Reference model: a frame is "sync, then five nibbles"; stalls just wait.
    bit         m_in_frame;
    logic [3:0] m_nib[$];
    logic [3:0] m_op, m_a, m_b;
    logic [7:0] m_c;
    bit         m_vld;
    int         m_idle;

    localparam int TIMEOUT = 16;

    typedef struct {
        bit         v;
        logic [3:0] d;
        bit         p;
        logic [3:0] eop, ea, eb;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_edge(input bit rst, input bit v, input logic [3:0] d);
        m_vld = 1'b0;
        if (rst) begin
            m_in_frame = 0;
            m_nib.delete();
            m_op = 0; m_a = 0; m_b = 0; m_c = 0;
            m_idle = 0;
        end else if (v) begin
            m_idle = 0;
            if (!m_in_frame) begin
                if (d == 4'hC) begin
                    m_in_frame = 1;
                    m_nib.delete();
                end
            end else begin
                m_nib.push_back(d);
                if (m_nib.size() == 5) begin
                    m_op = m_nib[0];
                    m_a  = m_nib[1];
                    m_b  = m_nib[2];
                    m_c  = {m_nib[4], m_nib[3]};
                    m_vld = 1'b1;
                    m_in_frame = 0;
                end
            end
        end else if (m_in_frame) begin
`ifdef RECEIVE_FSM_TIMEOUT_EN
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_in_frame = 0;
                m_idle = 0;
            end
`endif
        end
    endtask

    task automatic step(input bit v, input logic [3:0] d);
        rd_data_valid_i = v;
        rd_data_i       = d;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(reset, v, d);
        check("op_valid_o", {31'd0, op_valid_o}, {31'd0, m_vld});
        check("op_op", {28'd0, op_op}, {28'd0, m_op});
        check("op_a",  {28'd0, op_a},  {28'd0, m_a});
        check("op_b",  {28'd0, op_b},  {28'd0, m_b});
        check("op_c",  {24'd0, op_c},  {24'd0, m_c});
        if (op_valid_o) pulse_cycles.push_back(cyc);
    endtask

    task automatic send(input logic [3:0] n0, n1, n2, n3, n4, n5);
        step(1, n0); step(1, n1); step(1, n2);
        step(1, n3); step(1, n4); step(1, n5);
    endtask

    task automatic expect_outs(input string tag, input logic [3:0] eop, ea, eb,
                               input logic [7:0] ec);
        check({tag, "_op"}, {28'd0, op_op}, {28'd0, eop});
        check({tag, "_a"},  {28'd0, op_a},  {28'd0, ea});
        check({tag, "_b"},  {28'd0, op_b},  {28'd0, eb});
        check({tag, "_c"},  {24'd0, op_c},  {24'd0, ec});
    endtask

    function automatic vec_t mk(bit v, logic [3:0] d, bit p, logic [3:0] eop,
                                logic [3:0] ea, logic [3:0] eb, logic [7:0] ec);
        vec_t r;
        r.v = v; r.d = d; r.p = p; r.eop = eop; r.ea = ea; r.eb = eb; r.ec = ec;
        return r;
    endfunction

    initial begin
        int start;
        int npulse;
        bit v;
        logic [3:0] d;

        reset = 1'b1;
        rd_data_valid_i = 1'b0;
        rd_data_i = 4'h0;
        step(0, 0);
        step(0, 0);
        check("rst_valid", {31'd0, op_valid_o}, 32'd0);
        expect_outs("rst", 4'h0, 4'h0, 4'h0, 8'h00);
        reset = 1'b0;

        // Frame C,A,F,2,8,7 then garbage with no sync.
        tbl.push_back(mk(1, 4'hC, 0, 4'h0, 4'h0, 4'h0, 8'h00));
        tbl.push_back(mk(1, 4'hA, 0, 4'h0, 4'h0, 4'h0, 8'h00));
        tbl.push_back(mk(1, 4'hF, 0, 4'h0, 4'h0, 4'h0, 8'h00));
        tbl.push_back(mk(1, 4'h2, 0, 4'h0, 4'h0, 4'h0, 8'h00));
        tbl.push_back(mk(1, 4'h8, 0, 4'h0, 4'h0, 4'h0, 8'h00));
        tbl.push_back(mk(1, 4'h7, 1, 4'hA, 4'hF, 4'h2, 8'h78));
        tbl.push_back(mk(1, 4'hA, 0, 4'hA, 4'hF, 4'h2, 8'h78));
        tbl.push_back(mk(1, 4'h8, 0, 4'hA, 4'hF, 4'h2, 8'h78));
        tbl.push_back(mk(1, 4'hA, 0, 4'hA, 4'hF, 4'h2, 8'h78));
        tbl.push_back(mk(1, 4'hF, 0, 4'hA, 4'hF, 4'h2, 8'h78));
        tbl.push_back(mk(1, 4'h2, 0, 4'hA, 4'hF, 4'h2, 8'h78));
        tbl.push_back(mk(1, 4'h6, 0, 4'hA, 4'hF, 4'h2, 8'h78));
        tbl.push_back(mk(1, 4'hE, 0, 4'hA, 4'hF, 4'h2, 8'h78));
        tbl.push_back(mk(1, 4'h2, 0, 4'hA, 4'hF, 4'h2, 8'h78));
        tbl.push_back(mk(1, 4'hE, 0, 4'hA, 4'hF, 4'h2, 8'h78));
        tbl.push_back(mk(0, 4'hC, 0, 4'hA, 4'hF, 4'h2, 8'h78));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d);
            check($sformatf("tbl%0d_pulse", i), {31'd0, op_valid_o}, {31'd0, tbl[i].p});
            expect_outs($sformatf("tbl%0d", i), tbl[i].eop, tbl[i].ea, tbl[i].eb, tbl[i].ec);
        end

        // Stalled frame: 3 idle cycles after the "2" push the pulse out by 3.
        npulse = pulse_cycles.size();
        start = cyc;
        step(1, 4'hC); step(1, 4'h1); step(1, 4'h2);
        for (int i = 0; i < 3; i++) step(0, 4'($urandom_range(0, 15)));
        step(1, 4'h3); step(1, 4'h4); step(1, 4'h5);
        check("stall_npulse", pulse_cycles.size(), npulse + 1);
        check("stall_pulse_cyc", pulse_cycles[$], start + 9);
        expect_outs("stall", 4'h1, 4'h2, 4'h3, 8'h54);

        // Back-to-back frames, sync nibbles inside the first frame are data.
        pulse_cycles.delete();
        send(4'hC, 4'h1, 4'hC, 4'hC, 4'h0, 4'hF);
        expect_outs("b2b1", 4'h1, 4'hC, 4'hC, 8'hF0);
        send(4'hC, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6);
        expect_outs("b2b2", 4'h2, 4'h3, 4'h4, 8'h65);
        check("b2b_npulse", pulse_cycles.size(), 2);
        if (pulse_cycles.size() == 2)
            check("b2b_gap", pulse_cycles[1] - pulse_cycles[0], 6);

        // Reset mid-frame drops the frame and clears outputs.
        step(1, 4'hC); step(1, 4'h9); step(1, 4'h9);
        reset = 1'b1;
        step(0, 4'h0);
        reset = 1'b0;
        check("midrst_valid", {31'd0, op_valid_o}, 32'd0);
        expect_outs("midrst", 4'h0, 4'h0, 4'h0, 8'h00);
        step(1, 4'h1);
        step(0, 4'h0);
        check("midrst_after", {31'd0, op_valid_o}, 32'd0);

        // Reset on the completing edge suppresses the pulse.
        step(1, 4'hC); step(1, 4'h1); step(1, 4'h2); step(1, 4'h3); step(1, 4'h4);
        reset = 1'b1;
        step(1, 4'h5);
        reset = 1'b0;
        check("pendrst_valid", {31'd0, op_valid_o}, 32'd0);
        expect_outs("pendrst", 4'h0, 4'h0, 4'h0, 8'h00);
        step(0, 4'h0);
        check("pendrst_after", {31'd0, op_valid_o}, 32'd0);

`ifdef RECEIVE_FSM_TIMEOUT_EN
        send(4'hC, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3);
        expect_outs("to_pre", 4'h7, 4'h6, 4'h5, 8'h34);
        npulse = pulse_cycles.size();
        step(1, 4'hC); step(1, 4'h1);
        for (int i = 0; i < TIMEOUT; i++) step(0, 4'h0);
        step(1, 4'h2); step(1, 4'h3); step(1, 4'h4); step(1, 4'h5);
        step(0, 4'h0);
        check("to_npulse", pulse_cycles.size(), npulse);
        expect_outs("to_post", 4'h7, 4'h6, 4'h5, 8'h34);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                int n;
                n = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
                for (int k = 0; k < n; k++) step(0, 4'($urandom_range(0, 15)));
            end
            reset = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 99) < 70);
            d = ($urandom_range(0, 3) == 0) ? 4'hC : 4'($urandom_range(0, 15));
            step(v, d);
            reset = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
